// File: rtl/mux_bist_pkg.sv
// Shared types and helpers for the 4:1 mux BIST controller.
package mux_bist_pkg;

  localparam int PAT_W = 6;
  localparam logic [PAT_W-1:0] PAT_LAST = 6'd63;
  localparam int CNT_W = 7;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    WAIT,
    CHECK,
    DONE
  } state_t;

  // Golden mux response: select one of the four data bits by p[5:4].
  function automatic logic expected_out(input logic [PAT_W-1:0] p);
    logic [3:0] data;
    data = p[3:0];
    return data[p[5:4]];
  endfunction

endpackage

// File: rtl/mux_bist_pattern_gen.sv
// Pattern counter for the mux BIST; decodes the index into mux data/select fields.
module mux_bist_pattern_gen
  import mux_bist_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [PAT_W-1:0] p,
  output logic             pat_a,
  output logic             pat_b,
  output logic             pat_c,
  output logic             pat_d,
  output logic [1:0]       pat_sel
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p <= '0;
    end else if (clr) begin
      p <= '0;
    end else if (inc) begin
      p <= p + 1'b1;
    end
  end

  assign pat_a   = p[0];
  assign pat_b   = p[1];
  assign pat_c   = p[2];
  assign pat_d   = p[3];
  assign pat_sel = p[5:4];

endmodule

// File: rtl/mux_bist_ctrl.sv
// BIST sequencer and functional bypass for a 4:1 single-bit mux.
module mux_bist_ctrl
  import mux_bist_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             func_a,
  input  logic             func_b,
  input  logic             func_c,
  input  logic             func_d,
  input  logic [1:0]       func_sel,
  input  logic             mux_out,
  output logic             mux_a,
  output logic             mux_b,
  output logic             mux_c,
  output logic             mux_d,
  output logic [1:0]       mux_sel,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fault,
  output logic [CNT_W-1:0] fail_count,
  output logic [PAT_W-1:0] first_fail_pattern
);

  localparam logic [3:0] SETTLE_LOAD = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;

  state_t           state;
  logic [3:0]       settle_cnt;
  logic [PAT_W-1:0] p;
  logic             pat_a, pat_b, pat_c, pat_d;
  logic [1:0]       pat_sel;
  logic             run_start;
  logic             pat_inc;
  logic             mismatch;

  assign run_start = start && ((state == IDLE) || (state == DONE));
  assign pat_inc   = (state == CHECK) && (p != PAT_LAST);
  // Four-state compare so an X on the observed output is scored as a fault.
  assign mismatch  = (mux_out !== expected_out(p));

  mux_bist_pattern_gen u_pattern_gen (
    .clk     (clk),
    .rst     (rst),
    .clr     (run_start),
    .inc     (pat_inc),
    .p       (p),
    .pat_a   (pat_a),
    .pat_b   (pat_b),
    .pat_c   (pat_c),
    .pat_d   (pat_d),
    .pat_sel (pat_sel)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      settle_cnt         <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      fault              <= 1'b0;
      fail_count         <= '0;
      first_fail_pattern <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state              <= APPLY;
            busy               <= 1'b1;
            done               <= 1'b0;
            fault              <= 1'b0;
            fail_count         <= '0;
            first_fail_pattern <= '0;
          end
        end
        APPLY: begin
          settle_cnt <= SETTLE_LOAD;
          if (SETTLE_CYCLES > 0) state <= WAIT;
          else                   state <= CHECK;
        end
        WAIT: begin
          if (settle_cnt == '0) state <= CHECK;
          else                  settle_cnt <= settle_cnt - 1'b1;
        end
        CHECK: begin
          if (mismatch) begin
            fail_count <= fail_count + 1'b1;
            if (!fault) first_fail_pattern <= p;
            fault <= 1'b1;
          end
          if (p == PAT_LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= APPLY;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign pass = done & ~fault;

  always_comb begin
    mux_a   = func_a;
    mux_b   = func_b;
    mux_c   = func_c;
    mux_d   = func_d;
    mux_sel = func_sel;
    if (busy) begin
      mux_a   = pat_a;
      mux_b   = pat_b;
      mux_c   = pat_c;
      mux_d   = pat_d;
      mux_sel = pat_sel;
    end
  end

endmodule

// File: tb/tb_mux_bist_ctrl.sv
// Scoreboard bench: two controllers (settle 1 and settle 0) driving behavioural muxes with injected faults.
module tb_mux_bist_ctrl;

  typedef struct {
    int fc;
    int ff;
    int flt;
    int len;
  } exp_t;

  logic       clk, rst;
  logic       start1, start0;
  logic       func_a, func_b, func_c, func_d;
  logic [1:0] func_sel;

  logic       mux_out1, mux_a1, mux_b1, mux_c1, mux_d1;
  logic [1:0] mux_sel1;
  logic       busy1, done1, pass1, fault1;
  logic [6:0] fail_count1;
  logic [5:0] ff1;

  logic       mux_out0, mux_a0, mux_b0, mux_c0, mux_d0;
  logic [1:0] mux_sel0;
  logic       busy0, done0, pass0, fault0;
  logic [6:0] fail_count0;
  logic [5:0] ff0;

  int          mode1, mode0;
  logic [63:0] mask1, mask0;

  int vectors = 0;
  int miscompares = 0;

  exp_t q1[$];
  exp_t q0[$];

  mux_bist_ctrl #(.SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .start(start1),
    .func_a(func_a), .func_b(func_b), .func_c(func_c), .func_d(func_d), .func_sel(func_sel),
    .mux_out(mux_out1),
    .mux_a(mux_a1), .mux_b(mux_b1), .mux_c(mux_c1), .mux_d(mux_d1), .mux_sel(mux_sel1),
    .busy(busy1), .done(done1), .pass(pass1), .fault(fault1),
    .fail_count(fail_count1), .first_fail_pattern(ff1)
  );

  mux_bist_ctrl #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0),
    .func_a(func_a), .func_b(func_b), .func_c(func_c), .func_d(func_d), .func_sel(func_sel),
    .mux_out(mux_out0),
    .mux_a(mux_a0), .mux_b(mux_b0), .mux_c(mux_c0), .mux_d(mux_d0), .mux_sel(mux_sel0),
    .busy(busy0), .done(done0), .pass(pass0), .fault(fault0),
    .fail_count(fail_count0), .first_fail_pattern(ff0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mux under test: mode 0 = working mux with output flipped where mask is set,
  // mode 1 = stuck-at-0, mode 2 = stuck-at-1.
  function automatic logic mux_model(input logic a, input logic b, input logic c, input logic d,
                                     input logic [1:0] sel, input int mode, input logic [63:0] mask);
    logic [3:0] v;
    logic [5:0] idx;
    v   = {d, c, b, a};
    idx = {sel, d, c, b, a};
    if (mode == 1) return 1'b0;
    if (mode == 2) return 1'b1;
    return v[sel] ^ mask[idx];
  endfunction

  assign mux_out1 = mux_model(mux_a1, mux_b1, mux_c1, mux_d1, mux_sel1, mode1, mask1);
  assign mux_out0 = mux_model(mux_a0, mux_b0, mux_c0, mux_d0, mux_sel0, mode0, mask0);

  // Reference: walk all 64 patterns, count where the faulty mux disagrees with an ideal one.
  function automatic exp_t model(input int mode, input logic [63:0] mask, input int len);
    exp_t r;
    r.fc = 0; r.ff = 0; r.flt = 0; r.len = len;
    for (int p = 0; p < 64; p++) begin
      int e, obs;
      e = (p >> (p / 16)) & 1;
      if (mode == 1)      obs = 0;
      else if (mode == 2) obs = 1;
      else                obs = e ^ int'(mask[p]);
      if (obs != e) begin
        if (r.flt == 0) begin
          r.ff  = p;
          r.flt = 1;
        end
        r.fc++;
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  task automatic check_run(input string tag, input exp_t e, input logic [6:0] fc, input logic [5:0] ff,
                           input logic flt, input logic ps, input int len);
    chk({tag, "_fail_count"}, 32'(fc), e.fc);
    chk({tag, "_first_fail"}, 32'(ff), e.ff);
    chk({tag, "_fault"}, 32'(flt), e.flt);
    chk({tag, "_pass"}, 32'(ps), (e.flt != 0) ? 0 : 1);
    chk({tag, "_busy_len"}, len, e.len);
  endtask

  // Monitors: measure busy length and score results when done rises.
  int   blen1 = 0, blen0 = 0;
  logic pb1 = 1'b0, pd1 = 1'b0, pb0 = 1'b0, pd0 = 1'b0;
  exp_t m1, m0;

  always @(negedge clk) begin
    if (busy1 === 1'b1 && !pb1) blen1 = 1;
    else if (busy1 === 1'b1)    blen1++;
    if (done1 === 1'b1 && !pd1) begin
      if (q1.size() == 0) chk("s1_unexpected_done", 1, 0);
      else begin
        m1 = q1.pop_front();
        check_run("s1", m1, fail_count1, ff1, fault1, pass1, blen1);
      end
    end
    pb1 = (busy1 === 1'b1);
    pd1 = (done1 === 1'b1);
  end

  always @(negedge clk) begin
    if (busy0 === 1'b1 && !pb0) blen0 = 1;
    else if (busy0 === 1'b1)    blen0++;
    if (done0 === 1'b1 && !pd0) begin
      if (q0.size() == 0) chk("s0_unexpected_done", 1, 0);
      else begin
        m0 = q0.pop_front();
        check_run("s0", m0, fail_count0, ff0, fault0, pass0, blen0);
      end
    end
    pb0 = (busy0 === 1'b1);
    pd0 = (done0 === 1'b1);
  end

  task automatic check_bypass(input string tag);
    #1;
    chk({tag, "_a1"}, 32'(mux_a1), 32'(func_a));
    chk({tag, "_b1"}, 32'(mux_b1), 32'(func_b));
    chk({tag, "_c1"}, 32'(mux_c1), 32'(func_c));
    chk({tag, "_d1"}, 32'(mux_d1), 32'(func_d));
    chk({tag, "_sel1"}, 32'(mux_sel1), 32'(func_sel));
    chk({tag, "_a0"}, 32'(mux_a0), 32'(func_a));
    chk({tag, "_sel0"}, 32'(mux_sel0), 32'(func_sel));
  endtask

  task automatic run1(input int mode, input logic [63:0] mask, input bit noisy);
    mode1 = mode;
    mask1 = mask;
    q1.push_back(model(mode, mask, 192));
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    chk("s1_clear_fault", 32'(fault1), 0);
    chk("s1_clear_count", 32'(fail_count1), 0);
    chk("s1_clear_first", 32'(ff1), 0);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done1) break;
      start1 = noisy && ($urandom_range(0, 15) == 0);
    end
    start1 = 1'b0;
    chk("s1_done_seen", 32'(done1), 1);
  endtask

  task automatic run0(input int mode, input logic [63:0] mask);
    mode0 = mode;
    mask0 = mask;
    q0.push_back(model(mode, mask, 128));
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    chk("s0_clear_fault", 32'(fault0), 0);
    chk("s0_clear_count", 32'(fail_count0), 0);
    chk("s0_clear_first", 32'(ff0), 0);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done0) break;
    end
    chk("s0_done_seen", 32'(done0), 1);
  endtask

  initial begin
    rst = 1'b1;
    start1 = 1'b0; start0 = 1'b0;
    {func_a, func_b, func_c, func_d} = 4'b0;
    func_sel = 2'd0;
    mode1 = 0; mode0 = 0; mask1 = '0; mask0 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_done", 32'(done1), 0);
    chk("rst_pass", 32'(pass1), 0);
    chk("rst_fault", 32'(fault1), 0);
    chk("rst_fail_count", 32'(fail_count1), 0);
    chk("rst_first_fail", 32'(ff1), 0);
    chk("rst_busy0", 32'(busy0), 0);
    rst = 1'b0;

    {func_a, func_b, func_c, func_d} = 4'b1010;
    func_sel = 2'd2;
    check_bypass("byp_fixed");
    for (int i = 0; i < 4; i++) begin
      {func_a, func_b, func_c, func_d, func_sel} = 6'($urandom);
      check_bypass("byp_rand");
    end

    run1(0, '0, 1'b1);
    check_bypass("byp_done");
    run1(1, '0, 1'b0);
    run1(2, '0, 1'b0);
    run1(0, '1, 1'b0);
    for (int i = 0; i < 4; i++)
      run1(0, {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom}, 1'b1);

    // Abort a run mid-way with reset; its scoreboard entry is withdrawn.
    mode1 = 1;
    mask1 = '0;
    q1.push_back(model(1, '0, 192));
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    repeat (48) @(negedge clk);
    chk("mid_fault_before_rst", 32'(fault1), 1);
    {func_a, func_b, func_c, func_d, func_sel} = 6'($urandom);
    #2 rst = 1'b1;
    void'(q1.pop_back());
    #1;
    chk("mid_rst_busy", 32'(busy1), 0);
    chk("mid_rst_done", 32'(done1), 0);
    chk("mid_rst_pass", 32'(pass1), 0);
    chk("mid_rst_fault", 32'(fault1), 0);
    chk("mid_rst_fail_count", 32'(fail_count1), 0);
    chk("mid_rst_first_fail", 32'(ff1), 0);
    chk("mid_rst_a", 32'(mux_a1), 32'(func_a));
    chk("mid_rst_sel", 32'(mux_sel1), 32'(func_sel));
    @(negedge clk) rst = 1'b0;
    run1(0, {$urandom, $urandom} & {$urandom, $urandom}, 1'b0);

    run0(0, '0);
    run0(2, '0);
    run0(0, '0);
    run0(1, '0);
    run0(0, {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});

    repeat (3) @(negedge clk);
    chk("s1_queue_empty", q1.size(), 0);
    chk("s0_queue_empty", q0.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
